// File: rtl/mux4_scan_ctrl.sv
// Scan controller for a downstream 4x1 mux: walks the enabled channels in ascending order and captures one frame.
// Optional continuous rescanning is selected by the MUX4_SCAN_CONT_EN macro.
module mux4_scan_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       y,
    output logic [1:0] s,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state_r;
    logic [1:0] idx_r;
    logic [3:0] mask_r;
    logic [1:0] s_r;
    logic [3:0] frame_r;
    logic       frame_valid_r;
    logic       busy_r;
    logic [3:0] higher_s;

    // Lowest set bit of a non-empty channel mask.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] ch;
        if (m[0]) begin
            ch = 2'd0;
        end else if (m[1]) begin
            ch = 2'd1;
        end else if (m[2]) begin
            ch = 2'd2;
        end else begin
            ch = 2'd3;
        end
        return ch;
    endfunction

    // Enabled channels strictly above channel i.
    function automatic logic [3:0] above_mask(input logic [3:0] m, input logic [1:0] i);
        logic [3:0] sh;
        sh = 4'b1110 << i;
        return m & sh;
    endfunction

    assign higher_s = above_mask(mask_r, idx_r);

    // Scan FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            mask_r        <= 4'b0000;
            s_r           <= 2'd0;
            frame_r       <= 4'b0000;
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (mask != 4'b0000)) begin
                        mask_r  <= mask;
                        frame_r <= 4'b0000;
                        idx_r   <= lowest_ch(mask);
                        s_r     <= lowest_ch(mask);
                        busy_r  <= 1'b1;
                        state_r <= SCAN;
                    end
                end
                SCAN: begin
                    frame_r[idx_r] <= y;
                    if (higher_s != 4'b0000) begin
                        idx_r <= lowest_ch(higher_s);
                        s_r   <= lowest_ch(higher_s);
                    end else begin
                        s_r           <= 2'd0;
                        frame_valid_r <= 1'b1;
                        state_r       <= DONE;
                    end
                end
                DONE: begin
                    if (frame_ready) begin
                        frame_valid_r <= 1'b0;
`ifdef MUX4_SCAN_CONT_EN
                        // Rescan with the mask latched by the original start.
                        frame_r <= 4'b0000;
                        idx_r   <= lowest_ch(mask_r);
                        s_r     <= lowest_ch(mask_r);
                        state_r <= SCAN;
`else
                        idx_r   <= 2'd0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
`endif
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    idx_r         <= 2'd0;
                    s_r           <= 2'd0;
                    frame_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign s           = s_r;
    assign frame       = frame_r;
    assign frame_valid = frame_valid_r;
    assign busy        = busy_r;

endmodule

// File: doc/mux4_scan_ctrl.md
MUX4_SCAN_CTRL -- requirements
Module: mux4_scan_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  scan request, level-sampled each edge.
REQ-004 SHALL have port: mask  input  4  channel enable; bit k enables channel k; latched on accepted start.
REQ-005 SHALL have port: y  input  1  output of the downstream 4x1 mux.
REQ-006 SHALL have port: s  output  2  select driven into the downstream 4x1 mux.
REQ-007 SHALL have port: frame  output  4  captured samples; bit k holds channel k.
REQ-008 SHALL have port: frame_valid  output  1  frame holds a complete scan.
REQ-009 SHALL have port: frame_ready  input  1  consumer accepts frame.
REQ-010 SHALL have port: busy  output  1  high in SCAN or DONE.

Function
REQ-011 SHALL implement states IDLE, SCAN, DONE, with all outputs registered.
REQ-012 IDLE: start=1 and mask!=0 at an edge SHALL latch mask, clear frame to 0, load idx with the lowest enabled channel, and enter SCAN.
REQ-013 IDLE: start=1 with mask==0 SHALL be ignored; state stays IDLE and frame is unchanged.
REQ-014 SCAN: s SHALL equal idx for the whole cycle; at the closing edge frame[idx] SHALL load y.
REQ-015 SCAN: idx SHALL advance to the next higher enabled channel; disabled channels are skipped with zero cycles spent; disabled frame bits stay 0.
REQ-016 SCAN: after the highest enabled channel is captured, state SHALL go to DONE and frame_valid SHALL be 1 from that edge.
REQ-017 Latency: with N enabled channels, frame_valid SHALL rise exactly N edges after the accepting start edge.
REQ-018 DONE: frame and frame_valid SHALL hold until an edge with frame_ready=1; at that edge frame_valid SHALL go to 0 and state to IDLE (see REQ-026).
REQ-019 frame_ready SHALL be ignored outside DONE; an already-high frame_ready on DONE entry completes the handshake in one cycle.
REQ-020 start SHALL be ignored in SCAN and DONE; no queuing.
REQ-021 s SHALL be 2'b00 in IDLE and DONE.
REQ-022 frame SHALL retain its last value in IDLE until the next accepted start.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, s=0, frame=0, frame_valid=0, busy=0, idx=0, and latched mask=0, overriding all other inputs.
REQ-024 rst asserted mid-SCAN or in DONE SHALL abort the scan; the partial frame is discarded with no frame_valid pulse.
REQ-025 On the first edge with rst=0, start SHALL be acceptable under REQ-012.

Configuration
REQ-026 Macro MUX4_SCAN_CONT_EN SHALL select continuous mode.
- Defined: the DONE handshake edge re-enters SCAN directly with the latched mask, clears frame, and idx becomes the lowest enabled channel; start is unused after the first scan.
- A scan SHALL be stopped only by rst; busy stays 1.
REQ-027 Without MUX4_SCAN_CONT_EN, the DONE handshake SHALL return to IDLE (single-shot).

Verification
REQ-028 Bench SHALL cover these directed scenarios:
- mask=4'b1111, start pulse, y driven to 1,0,1,1 for s=0..3 -> s sequence 0,1,2,3; frame=4'b1101 with frame_valid 4 edges after start; frame_ready=1 -> IDLE.
- mask=4'b1010, y=1 always -> s visits only 1 then 3; frame=4'b1010; frame_valid 2 edges after start.
- mask=4'b0000, start=1 -> no state change; busy=0; frame unchanged.
- frame_ready held 0 for 5 cycles in DONE -> frame and frame_valid stable; start during this window ignored.
- rst=1 at the edge capturing channel 2 with mask=4'b1111 -> all outputs 0 next cycle; no frame_valid.
- With MUX4_SCAN_CONT_EN and mask=4'b0001, frame_ready=1 -> new scan each 2 cycles; s=0; frame tracks y.
